onchip_mem_test_master: RTL and testbench

- Avalon-MM master that drives the Qsys single-port on-chip RAM slave: 32-bit data, 15-bit word address, 25000 words, no waitrequest, fixed read latency.
- On command it either fills a word range with a deterministic pattern, or reads the range back and checks it.
- Results are error count, first failing address and a done pulse.
- Used for power-on RAM self-test and for preloading frame/line buffers in the D8M video path.

---
 rtl/onchip_mem_test_master_if.sv | 23 ++
 rtl/onchip_mem_test_master.sv | 163 ++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM link between the memory test master and a single-port on-chip RAM slave.
// chipselect qualifies a transfer in the cycle it is high. There is no waitrequest, so every
// selected cycle completes. readdata is valid READ_LATENCY cycles after a read address.
interface onchip_mem_test_master_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, byteenable, chipselect, write, writedata,
      input  readdata
   );
   modport slave (
      input  address, byteenable, chipselect, write, writedata,
      output readdata
   );
endinterface

// File: rtl/onchip_mem_test_master.sv
// On-chip RAM test master: fills a word range with seed+i, or reads it back and counts mismatches.
// Addresses wrap modulo DEPTH. Results are held until the next accepted command.
module onchip_mem_test_master #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 25000,
   parameter int READ_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     mode,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [15:0]              num_words,
   input  logic [DATA_W-1:0]        seed,
   output logic                     busy,
   output logic                     done,
   output logic                     cmd_err,
   output logic                     err_flag,
   output logic [15:0]              err_count,
   output logic [ADDR_W-1:0]        first_err_addr,
   output logic [2:0]               state_dbg,
   onchip_mem_test_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [15:0]       DEPTH_N   = 16'(DEPTH);

   state_t            state;
   logic [15:0]       remain;
   logic [DATA_W-1:0] pat;
   logic [DW-1:0]     drain_cnt;

   // Expected data and address travel alongside each outstanding read.
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [DATA_W-1:0]       pipe_exp  [READ_LATENCY];
   logic [ADDR_W-1:0]       pipe_addr [READ_LATENCY];

   logic [ADDR_W-1:0] next_addr;
   logic [15:0]       n_eff;
   logic              base_ok;
   logic              mismatch;

   assign next_addr = (bus.address == LAST_ADDR) ? '0 : bus.address + ADDR_W'(1);
   assign n_eff     = (num_words > DEPTH_N) ? DEPTH_N : num_words;
   assign base_ok   = ({1'b0, base_addr} < DEPTH_A);
   assign mismatch  = pipe_vld[READ_LATENCY-1] &&
                      (bus.readdata != pipe_exp[READ_LATENCY-1]);

   assign bus.byteenable = '1;
   assign state_dbg      = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         cmd_err        <= 1'b0;
         err_flag       <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         bus.address    <= '0;
         bus.chipselect <= 1'b0;
         bus.write      <= 1'b0;
         bus.writedata  <= '0;
         remain         <= '0;
         pat            <= '0;
         drain_cnt      <= '0;
         pipe_vld       <= '0;
      end else begin
         for (int k = READ_LATENCY - 1; k > 0; k--) begin
            pipe_vld[k]  <= pipe_vld[k-1];
            pipe_exp[k]  <= pipe_exp[k-1];
            pipe_addr[k] <= pipe_addr[k-1];
         end
         pipe_vld[0]  <= (state == S_READ);
         pipe_exp[0]  <= pat;
         pipe_addr[0] <= bus.address;

         if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            err_flag <= 1'b1;
            if (!err_flag) first_err_addr <= pipe_addr[READ_LATENCY-1];
         end

         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy           <= 1'b1;
                  cmd_err        <= 1'b0;
                  err_flag       <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  pat            <= seed;
                  if (!base_ok) begin
                     cmd_err <= 1'b1;
                     done    <= 1'b1;
                     state   <= S_DONE;
                  end else if (n_eff == 16'd0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     remain         <= n_eff - 16'd1;
                     bus.address    <= base_addr;
                     bus.chipselect <= 1'b1;
                     bus.write      <= ~mode;
                     if (!mode) bus.writedata <= seed;
                     state <= mode ? S_READ : S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (remain == 16'd0) begin
                  bus.chipselect <= 1'b0;
                  bus.write      <= 1'b0;
                  done           <= 1'b1;
                  state          <= S_DONE;
               end else begin
                  remain        <= remain - 16'd1;
                  bus.address   <= next_addr;
                  bus.writedata <= bus.writedata + DATA_W'(1);
               end
            end
            S_READ: begin
               if (remain == 16'd0) begin
                  bus.chipselect <= 1'b0;
                  drain_cnt      <= DW'(READ_LATENCY - 1);
                  state          <= S_DRAIN;
               end else begin
                  remain      <= remain - 16'd1;
                  bus.address <= next_addr;
                  pat         <= pat + DATA_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: RAM slave model plus a reference model computing expected
// writes, completion cycle and check results from the address/pattern rules.
module tb_onchip_mem_test_master;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 25000;
   localparam int W      = ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [15:0]       num_words = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              busy, done, cmd_err, err_flag;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;
   logic [2:0]        state_dbg;

   onchip_mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   onchip_mem_test_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LATENCY(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .num_words(num_words), .seed(seed),
      .busy(busy), .done(done), .cmd_err(cmd_err), .err_flag(err_flag),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .state_dbg(state_dbg), .bus(bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   // RAM slave with a bench-side port for corrupting words
   bit [DATA_W-1:0] mem [DEPTH];
   logic              inj_en = 1'b0;
   logic [ADDR_W-1:0] inj_addr = '0;
   logic [DATA_W-1:0] inj_data = '0;

   always @(posedge clk) begin
      if (inj_en) mem[inj_addr] <= inj_data;
      else if (bus.chipselect && bus.write) mem[bus.address] <= bus.writedata;
      if (bus.chipselect && !bus.write) bus.readdata <= mem[bus.address];
   end

   // reference model and scoreboard
   bit [DATA_W-1:0] ref_mem [DEPTH];
   logic [W-1:0]    exp_q[$];
   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic inject(input int a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      inj_en = 1'b1; inj_addr = ADDR_W'(a); inj_data = d;
      @(negedge clk);
      inj_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_cmd(input bit m, input int b, input int n, input logic [DATA_W-1:0] sd,
                          input bit glitch);
      int n_eff, lat, a, done_at, extra_done, cs_n, gaps, exp_errs, exp_first;
      bit rej;
      logic [DATA_W-1:0] d;
      logic [W-1:0] e;
      rej   = (b >= DEPTH);
      n_eff = rej ? 0 : ((n > DEPTH) ? DEPTH : n);
      lat   = (n_eff == 0) ? 1 : (m ? n_eff + 2 : n_eff + 1);
      exp_errs = 0; exp_first = 0;
      for (int i = 0; i < n_eff; i++) begin
         a = (b + i) % DEPTH;
         d = sd + DATA_W'(i);
         if (!m) begin
            exp_q.push_back({a[ADDR_W-1:0], d});
            ref_mem[a] = d;
         end else if (ref_mem[a] != d) begin
            if (exp_errs == 0) exp_first = a;
            exp_errs++;
         end
      end

      @(negedge clk);
      start = 1'b1; mode = m; base_addr = ADDR_W'(b); num_words = 16'(n); seed = sd;
      done_at = 0; extra_done = 0; cs_n = 0; gaps = 0;
      for (int k = 1; k <= lat + 4; k++) begin
         @(negedge clk);
         start = glitch && k > 1 && (k == 2 || k == lat);
         if (k == 1) check_eq("busy_rise", busy, 1);
         if (bus.chipselect) begin
            cs_n++;
            if (k > n_eff) gaps++;
         end else if (k <= n_eff) begin
            gaps++;
         end
         if (bus.chipselect && bus.write) begin
            if (exp_q.size() == 0) check_eq("unexpected_write", bus.address, 0);
            else begin
               e = exp_q.pop_front();
               check_eq("write", {bus.address, bus.writedata}, e);
            end
         end
         if (done) begin
            if (done_at == 0) done_at = k;
            else extra_done++;
         end
      end
      start = 1'b0;
      check_eq("done_cycle", done_at, lat);
      check_eq("extra_done", extra_done, 0);
      check_eq("cs_cycles", cs_n, n_eff);
      check_eq("cs_gaps", gaps, 0);
      check_eq("exp_q_left", exp_q.size(), 0);
      check_eq("cmd_err", cmd_err, rej);
      check_eq("err_count", err_count, exp_errs);
      check_eq("err_flag", err_flag, exp_errs != 0);
      check_eq("first_err_addr", first_err_addr, exp_first);
      check_eq("busy_idle", busy, 0);
      exp_q.delete();
   endtask

   int dn;
   int lf_base, lf_n;
   logic [DATA_W-1:0] lf_seed;

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_cmd_err", cmd_err, 0);
      check_eq("rst_err_flag", err_flag, 0);
      check_eq("rst_err_count", err_count, 0);
      check_eq("rst_first_err", first_err_addr, 0);
      check_eq("rst_address", bus.address, 0);
      check_eq("rst_byteenable", bus.byteenable, 4'hF);
      check_eq("rst_chipselect", bus.chipselect, 0);
      check_eq("rst_write", bus.write, 0);
      check_eq("rst_writedata", bus.writedata, 0);
      reset = 1'b0;

      // fill then clean check
      run_cmd(0, 0, 16, 32'h1000_0000, 0);
      run_cmd(1, 0, 16, 32'h1000_0000, 0);
      // short fill timing
      run_cmd(0, 100, 3, 32'h55, 0);
      // injected errors
      run_cmd(0, 0, 8, 32'h0, 0);
      inject(5, 32'hDEAD);
      inject(7, 32'h0000_0001);
      inject(7, 32'h0);
      run_cmd(1, 0, 8, 32'h0, 0);
      check_eq("inj_err_count", err_count, 2);
      check_eq("inj_first_addr", first_err_addr, 5);
      // wrap-around
      run_cmd(0, 24998, 4, 32'd7, 0);
      run_cmd(1, 24998, 4, 32'd7, 0);
      check_eq("wrap_mem0", mem[0], 32'd9);
      // boundaries
      run_cmd(0, 50, 0, 32'h1, 0);
      run_cmd(1, 25000, 5, 32'h1, 0);
      run_cmd(0, 32767, 5, 32'h1, 0);
      run_cmd(0, 1234, 30000, $urandom, 0);
      // starts while busy and in the done cycle are ignored
      run_cmd(0, 300, 10, 32'hA000_0000, 1);
      run_cmd(1, 300, 10, 32'hA000_0000, 1);

      // reset in the 5th cycle of a failing 10-word check
      @(negedge clk);
      start = 1'b1; mode = 1'b1; base_addr = 15'd200; num_words = 16'd10; seed = 32'hFFFF_0000;
      dn = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dn++;
         if (k == 5) reset = 1'b1;
      end
      check_eq("midrst_cs", bus.chipselect, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_err_count", err_count, 0);
      check_eq("midrst_err_flag", err_flag, 0);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) dn++;
      end
      check_eq("midrst_no_done", dn, 0);

      // randomized commands against the model
      lf_base = 0; lf_n = 16; lf_seed = 32'h1000_0000;
      for (int it = 0; it < 24; it++) begin
         int rb, rn;
         rb = $urandom_range(0, 25100);
         rn = $urandom_range(0, 40);
         case ($urandom_range(0, 3))
            0, 1: begin
               run_cmd(0, rb, rn, $urandom, 0);
               if (rb < DEPTH) begin lf_base = rb; lf_n = rn; lf_seed = seed; end
            end
            2: begin
               if (lf_n > 0 && $urandom_range(0, 1) == 1)
                  inject((lf_base + $urandom_range(0, lf_n - 1)) % DEPTH, $urandom);
               run_cmd(1, lf_base, lf_n, lf_seed, 0);
            end
            default: run_cmd(1, rb, rn, $urandom, $urandom_range(0, 1) == 1);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
